// File: rtl/lsu_rmw_if.sv
// Datapath-side request/response bundle of the load/store initiator.
interface lsu_rmw_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, we, size, sign_ext, addr, wdata,
                   input  busy, done, rdata, err);
   modport slave  (input  req, we, size, sign_ext, addr, wdata,
                   output busy, done, rdata, err);
endinterface

// File: rtl/lsu_rmw.sv
// Multi-cycle load/store initiator: byte/half/word accesses onto a word-wide
// data memory, sub-word stores done as read-modify-write.
module lsu_rmw #(
   parameter int DM_AW = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   lsu_rmw_if.slave          cpu,
   output logic [DM_AW-1:0]  dm_addr,
   output logic              dm_MemRead,
   output logic              dm_MemWrite,
   output logic [31:0]       dm_write_data,
   input  logic [31:0]       dm_read_data
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t            state, state_n;
   logic              we_q, sext_q, err_q;
   logic [1:0]        size_q;
   logic [DM_AW+1:0]  addr_q;
   logic [31:0]       wdata_q, word_q, rdata_q;
   logic              mis;
   logic [31:0]       load_val, merged;
   logic [7:0]        lb;
   logic [15:0]       lh;

   assign mis = (cpu.size == 2'b11) ||
                (cpu.size == 2'b01 && cpu.addr[0]) ||
                (cpu.size == 2'b10 && cpu.addr[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n     = state;
      cpu.busy    = (state != IDLE);
      cpu.done    = 1'b0;
      dm_MemRead  = 1'b0;
      dm_MemWrite = 1'b0;
      case (state)
         IDLE: begin
            if (cpu.req) begin
               if (mis)                       state_n = DONE;
               else if (!cpu.we)              state_n = READ;
               else if (cpu.size == 2'b10)    state_n = WRITE;
               else                           state_n = READ;
            end
         end
         READ: begin
            dm_MemRead = 1'b1;
            state_n    = we_q ? WRITE : DONE;
         end
         WRITE: begin
            dm_MemWrite = 1'b1;
            state_n     = DONE;
         end
         DONE: begin
            cpu.done = 1'b1;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Load extraction works straight off the memory read data so rdata is
   // ready in the DONE cycle.
   always_comb begin
      lb = dm_read_data[{addr_q[1:0], 3'b000} +: 8];
      lh = dm_read_data[{addr_q[1], 4'b0000} +: 16];
      case (size_q)
         2'b00:   load_val = {{24{sext_q & lb[7]}}, lb};
         2'b01:   load_val = {{16{sext_q & lh[15]}}, lh};
         default: load_val = dm_read_data;
      endcase
   end

   always_comb begin
      merged = word_q;
      case (size_q)
         2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         sext_q  <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
         rdata_q <= '0;
      end else begin
         if (state == IDLE && cpu.req) begin
            we_q    <= cpu.we;
            sext_q  <= cpu.sign_ext;
            size_q  <= cpu.size;
            addr_q  <= cpu.addr[DM_AW+1:0];
            wdata_q <= cpu.wdata;
            err_q   <= mis;
         end
         if (state == READ) begin
            word_q <= dm_read_data;
            if (!we_q) rdata_q <= load_val;
         end
      end
   end

   assign dm_addr       = addr_q[DM_AW+1:2];
   assign dm_write_data = (state == WRITE) ? merged : 32'h0;
   assign cpu.rdata     = rdata_q;
   assign cpu.err       = (state == DONE) && err_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw: per-cycle comparison against a transaction-level
// model plus literal checks of key results.
module tb_lsu_rmw;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  dm_addr;
   logic        dm_MemRead, dm_MemWrite;
   logic [31:0] dm_write_data, dm_read_data;
   logic [31:0] dmem [16];
   logic [31:0] mmem [16];

   lsu_rmw_if bus();

   lsu_rmw #(.DM_AW(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cpu           (bus),
      .dm_addr       (dm_addr),
      .dm_MemRead    (dm_MemRead),
      .dm_MemWrite   (dm_MemWrite),
      .dm_write_data (dm_write_data),
      .dm_read_data  (dm_read_data)
   );

   always #5 clk = ~clk;

   assign dm_read_data = dmem[dm_addr];
   always @(posedge clk) if (dm_MemWrite) dmem[dm_addr] <= dm_write_data;

   typedef struct packed {
      logic        busy, done, rd, wr, err;
      logic [3:0]  a;
      logic [31:0] wd;
      logic [31:0] rv;
   } rec_t;

   rec_t        q[$];
   logic [31:0] cur_rdata = 32'h0;
   bit          chk_en = 1'b0;
   int          nvec = 0, nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [31:0] a, input bit sx);
      logic [31:0] v;
      if (sz == 2'b00) begin
         v = (w >> (8 * a[1:0])) & 32'hFF;
         if (sx && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
         v = (w >> (16 * a[1])) & 32'hFFFF;
         if (sx && v[15]) v = v | 32'hFFFF_0000;
      end else v = w;
      return v;
   endfunction

   function automatic logic [31:0] st_model(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] mask;
      int sh;
      sh   = (sz == 2'b00) ? 8 * a[1:0] : 16 * a[1];
      mask = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
      return (w & ~mask) | ((wd << sh) & mask);
   endfunction

   function automatic rec_t mk(input bit rd, input bit wr, input bit dn, input bit er,
                               input logic [3:0] a, input logic [31:0] wd);
      rec_t r;
      r = '0;
      r.busy = 1'b1; r.rd = rd; r.wr = wr; r.done = dn; r.err = er;
      r.a = a; r.wd = wd; r.rv = cur_rdata;
      return r;
   endfunction

   // Expected behaviour, cycle by cycle, of one accepted request.
   function automatic int model_push(input bit we, input logic [1:0] sz, input bit sx,
                                     input logic [31:0] a, input logic [31:0] wd);
      bit          mis;
      logic [3:0]  wi;
      logic [31:0] nw;
      mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 0);
      wi  = a[5:2];
      if (mis) begin
         q.push_back(mk(0, 0, 1, 1, 0, 0));
         return 1;
      end else if (!we) begin
         q.push_back(mk(1, 0, 0, 0, wi, 0));
         cur_rdata = ld_model(mmem[wi], sz, a, sx);
         q.push_back(mk(0, 0, 1, 0, 0, 0));
         return 2;
      end else if (sz == 2'b10) begin
         mmem[wi] = wd;
         q.push_back(mk(0, 1, 0, 0, wi, wd));
         q.push_back(mk(0, 0, 1, 0, 0, 0));
         return 2;
      end else begin
         nw = st_model(mmem[wi], sz, a, wd);
         mmem[wi] = nw;
         q.push_back(mk(1, 0, 0, 0, wi, 0));
         q.push_back(mk(0, 1, 0, 0, wi, nw));
         q.push_back(mk(0, 0, 1, 0, 0, 0));
         return 3;
      end
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         rec_t r;
         if (q.size() > 0) r = q.pop_front();
         else begin
            r = '0;
            r.rv = cur_rdata;
         end
         chk("busy", {31'b0, bus.busy}, {31'b0, r.busy});
         chk("done", {31'b0, bus.done}, {31'b0, r.done});
         chk("dm_MemRead", {31'b0, dm_MemRead}, {31'b0, r.rd});
         chk("dm_MemWrite", {31'b0, dm_MemWrite}, {31'b0, r.wr});
         chk("rdata", bus.rdata, r.rv);
         if (r.rd || r.wr) chk("dm_addr", {28'b0, dm_addr}, {28'b0, r.a});
         if (r.wr) chk("dm_write_data", dm_write_data, r.wd);
         if (r.done) chk("err", {31'b0, bus.err}, {31'b0, r.err});
      end
   end

   // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the IDLE
   // cycle following DONE. With hold set, req stays high throughout.
   task automatic access(input bit we, input logic [1:0] sz, input bit sx,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold);
      int n;
      bus.req = 1'b1; bus.we = we; bus.size = sz; bus.sign_ext = sx;
      bus.addr = a; bus.wdata = wd;
      @(posedge clk); #1;
      if (!hold) bus.req = 1'b0;
      n = model_push(we, sz, sx, a, wd);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         dmem[i] = 32'h0;
         mmem[i] = 32'h0;
      end
      bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
      bus.addr = 32'h0; bus.wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_en = 1'b1;
      chk("reset busy", {31'b0, bus.busy}, 32'h0);
      chk("reset rdata", bus.rdata, 32'h0);
      chk("reset dm_addr", {28'b0, dm_addr}, 32'h0);
      chk("reset dm_write_data", dm_write_data, 32'h0);
      @(posedge clk); #1;

      // word store then load
      access(1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 0);
      chk("mem2 after sw", dmem[2], 32'hDEADBEEF);
      access(0, 2'b10, 0, 32'h08, 32'h0, 0);
      chk("lw 0x08", bus.rdata, 32'hDEADBEEF);

      // byte store read-modify-write
      access(1, 2'b10, 0, 32'h08, 32'h11223344, 0);
      access(1, 2'b00, 0, 32'h09, 32'h000000AA, 0);
      chk("mem2 after sb", dmem[2], 32'h1122AA44);
      access(1, 2'b01, 0, 32'h06, 32'hFFFFBEEF, 0);
      chk("mem1 after sh", dmem[1], 32'hBEEF0000);

      // sub-word loads
      access(1, 2'b10, 0, 32'h0C, 32'h8000FF7F, 0);
      access(0, 2'b00, 1, 32'h0C, 32'h0, 0);
      chk("lb 0x0C", bus.rdata, 32'h0000007F);
      access(0, 2'b00, 1, 32'h0D, 32'h0, 0);
      chk("lb 0x0D", bus.rdata, 32'hFFFFFFFF);
      access(0, 2'b00, 0, 32'h0D, 32'h0, 0);
      chk("lbu 0x0D", bus.rdata, 32'h000000FF);
      access(0, 2'b01, 1, 32'h0E, 32'h0, 0);
      chk("lh 0x0E", bus.rdata, 32'hFFFF8000);
      access(0, 2'b01, 0, 32'h0E, 32'h0, 0);
      chk("lhu 0x0E", bus.rdata, 32'h00008000);

      // misalignment
      access(0, 2'b10, 0, 32'h0A, 32'h0, 0);
      chk("lw misaligned rdata", bus.rdata, 32'h00008000);
      access(1, 2'b01, 0, 32'h0B, 32'h00001234, 0);
      chk("sh misaligned mem2", dmem[2], 32'h1122AA44);
      access(0, 2'b11, 1, 32'h0C, 32'h0, 0);
      chk("size11 rdata", bus.rdata, 32'h00008000);

      // req held high: back-to-back accepts only from IDLE
      access(0, 2'b10, 0, 32'h08, 32'h0, 1);
      access(0, 2'b00, 1, 32'h0B, 32'h0, 1);
      chk("lb 0x0B", bus.rdata, 32'h00000011);
      access(1, 2'b00, 0, 32'h08, 32'h000000C3, 1);
      access(0, 2'b01, 0, 32'h0A, 32'h0, 0);
      chk("lhu 0x0A", bus.rdata, 32'h00001122);
      chk("mem2 after held sb", dmem[2], 32'h1122AAC3);

      // reset during the READ of a byte store
      bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.sign_ext = 1'b0;
      bus.addr = 32'h0D; bus.wdata = 32'h55;
      @(posedge clk); #1;
      bus.req = 1'b0;
      q.push_back(mk(1, 0, 0, 0, 4'd3, 0));
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cur_rdata = 32'h0;
      chk("post-reset busy", {31'b0, bus.busy}, 32'h0);
      chk("post-reset rdata", bus.rdata, 32'h0);
      chk("post-reset dm_addr", {28'b0, dm_addr}, 32'h0);
      chk("post-reset dm_write_data", dm_write_data, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("mem3 after aborted sb", dmem[3], 32'h8000FF7F);
      chk("model mem3", mmem[3], dmem[3]);
      chk("pending records", q.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
